// File: rtl/pe_seq_pkg.sv
// Shared op/state encodings and parameter defaults for the PE stream sequencer.
// Optional stall counter is enabled by defining PE_SEQ_PERF_EN when building the top.
package pe_seq_pkg;

    localparam int CNT_W_DEF     = 8;
    localparam int SHIFT_W_DEF   = 6;
    localparam int DRAIN_MAX_DEF = 16;

    typedef enum logic [1:0] {
        OP_PRELOAD = 2'b00,
        OP_COMPUTE = 2'b01
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        STREAM = 2'b01,
        DRAIN  = 2'b10
    } state_e;

    function automatic logic is_legal_op(input logic [1:0] op);
        return (op == OP_PRELOAD) || (op == OP_COMPUTE);
    endfunction

endpackage

// File: rtl/pe_seq_result_tracker.sv
// Counts PE result beats for the active command and decides when DRAIN ends,
// either because every expected result arrived or because the drain timer expired.
module pe_seq_result_tracker
    import pe_seq_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int DRAIN_MAX = DRAIN_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             busy,
    input  logic             in_drain,
    input  logic             pe_out_valid,
    input  logic [CNT_W-1:0] rows,
    output logic             finish,
    output logic             timeout
);

    localparam int                TMR_W    = $clog2(DRAIN_MAX + 1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(DRAIN_MAX - 1);

    logic [CNT_W-1:0] res_cnt_q;
    logic [CNT_W-1:0] res_cnt_d;
    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_d;
    logic             got_all;
    logic             expired;

    always_comb begin
        res_cnt_d = res_cnt_q;
        // Saturate so a chatty PE can never wrap the count back below rows.
        if (clear) begin
            res_cnt_d = '0;
        end else if (busy && pe_out_valid && (res_cnt_q != '1)) begin
            res_cnt_d = res_cnt_q + CNT_W'(1);
        end

        got_all = (res_cnt_q >= rows);
        expired = (timer_q == TMR_LAST);
        finish  = in_drain && (got_all || expired);
        timeout = in_drain && !got_all && expired;

        timer_d = (in_drain && !finish) ? timer_q + TMR_W'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_cnt_q <= '0;
            timer_q   <= '0;
        end else begin
            res_cnt_q <= res_cnt_d;
            timer_q   <= timer_d;
        end
    end

endmodule

// File: rtl/pe_stream_sequencer.sv
// Control sequencer for one registered PE tile: accepts PRELOAD/COMPUTE commands,
// gates the operand stream into the PE and reports done/timeout. Optional: PE_SEQ_PERF_EN.
module pe_stream_sequencer
    import pe_seq_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int SHIFT_W   = SHIFT_W_DEF,
    parameter int DRAIN_MAX = DRAIN_MAX_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [CNT_W-1:0]   cmd_rows,
    input  logic [SHIFT_W-1:0] cmd_shift,
    input  logic               op_valid,
    output logic               op_ready,
    output logic               pe_in_valid,
    output logic               pe_in_propagate,
    output logic [SHIFT_W-1:0] pe_in_shift,
    input  logic               pe_out_valid,
    output logic               busy,
    output logic               done,
    output logic               err_illegal,
    output logic               err_timeout,
    output logic [31:0]        perf_stall_cnt,
    output logic [1:0]         dbg_state
);

    // Handshakes (cmd and op): a transfer happens on the rising CLK where
    // valid && ready; ready is a registered function of state only and never
    // depends on valid, and valid is not expected to wait for ready.

    state_e             state_q;
    state_e             state_d;
    op_e                op_q;
    op_e                op_d;
    logic [CNT_W-1:0]   rows_q;
    logic [CNT_W-1:0]   rows_d;
    logic [SHIFT_W-1:0] shift_q;
    logic [SHIFT_W-1:0] shift_d;
    logic               prop_q;
    logic               prop_d;
    logic [CNT_W-1:0]   beat_cnt_q;
    logic [CNT_W-1:0]   beat_cnt_d;
    logic               pe_in_valid_q;
    logic               pe_in_valid_d;
    logic               op_ready_q;
    logic               op_ready_d;
    logic               cmd_ready_q;
    logic               cmd_ready_d;
    logic               busy_q;
    logic               busy_d;
    logic               done_q;
    logic               done_d;
    logic               err_illegal_q;
    logic               err_illegal_d;
    logic               err_timeout_q;
    logic               err_timeout_d;

    logic               cmd_accept;
    logic               cmd_legal;
    logic               op_hs;
    logic               last_beat;
    logic               trk_clear;
    logic               trk_finish;
    logic               trk_timeout;

    always_comb begin
        cmd_accept = cmd_valid && cmd_ready_q;
        cmd_legal  = is_legal_op(cmd_op);
        op_hs      = op_valid && op_ready_q;
        last_beat  = op_hs && (beat_cnt_q == rows_q - CNT_W'(1));
        trk_clear  = 1'b0;

        state_d       = state_q;
        op_d          = op_q;
        rows_d        = rows_q;
        shift_d       = shift_q;
        prop_d        = prop_q;
        beat_cnt_d    = beat_cnt_q;
        err_illegal_d = 1'b0;
        done_d        = 1'b0;
        err_timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    if (cmd_legal) begin
                        op_d       = op_e'(cmd_op);
                        rows_d     = cmd_rows;
                        shift_d    = cmd_shift;
                        beat_cnt_d = '0;
                        trk_clear  = 1'b1;
                        if (cmd_op == OP_PRELOAD) begin
                            prop_d = !prop_q;
                        end
                        // A zero-row command has nothing to stream; it drains with an
                        // expected result count of zero and completes immediately.
                        state_d = (cmd_rows == '0) ? DRAIN : STREAM;
                    end else begin
                        err_illegal_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (op_hs) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (last_beat) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (trk_finish) begin
                    state_d       = IDLE;
                    done_d        = 1'b1;
                    err_timeout_d = trk_timeout;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pe_in_valid_d = op_hs;
        op_ready_d    = (state_d == STREAM);
        // Holding ready low on the done cycle keeps a new command from
        // overlapping the completion pulse of the previous one.
        cmd_ready_d   = (state_d == IDLE) && (state_q == IDLE);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            op_q          <= OP_PRELOAD;
            rows_q        <= '0;
            shift_q       <= '0;
            prop_q        <= 1'b0;
            beat_cnt_q    <= '0;
            pe_in_valid_q <= 1'b0;
            op_ready_q    <= 1'b0;
            cmd_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            rows_q        <= rows_d;
            shift_q       <= shift_d;
            prop_q        <= prop_d;
            beat_cnt_q    <= beat_cnt_d;
            pe_in_valid_q <= pe_in_valid_d;
            op_ready_q    <= op_ready_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_illegal_q <= err_illegal_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    pe_seq_result_tracker #(
        .CNT_W     (CNT_W),
        .DRAIN_MAX (DRAIN_MAX)
    ) u_tracker (
        .clk          (CLK),
        .rst          (RST),
        .clear        (trk_clear),
        .busy         (state_q != IDLE),
        .in_drain     (state_q == DRAIN),
        .pe_out_valid (pe_out_valid),
        .rows         (rows_q),
        .finish       (trk_finish),
        .timeout      (trk_timeout)
    );

`ifdef PE_SEQ_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_stall_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        if ((state_q == STREAM) && !op_valid) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_stall_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
`else
    assign perf_stall_cnt = 32'd0;
`endif

    assign cmd_ready       = cmd_ready_q;
    assign op_ready        = op_ready_q;
    assign pe_in_valid     = pe_in_valid_q;
    assign pe_in_propagate = prop_q;
    // PRELOAD never shifts; the latched shift only reaches the PE for COMPUTE.
    assign pe_in_shift     = (op_q == OP_COMPUTE) ? shift_q : '0;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err_illegal     = err_illegal_q;
    assign err_timeout     = err_timeout_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_pe_stream_sequencer.sv
// Directed bench for pe_stream_sequencer with a 3-cycle echo PE model;
// stall-count expectation follows PE_SEQ_PERF_EN.
module tb_pe_stream_sequencer;
    import pe_seq_pkg::*;

    localparam int CNT_W     = 8;
    localparam int SHIFT_W   = 6;
    localparam int DRAIN_MAX = 16;
`ifdef PE_SEQ_PERF_EN
    localparam int EXP_STALL = 1;
`else
    localparam int EXP_STALL = 0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [1:0]         cmd_op = 2'b00;
    logic [CNT_W-1:0]   cmd_rows = '0;
    logic [SHIFT_W-1:0] cmd_shift = '0;
    logic               op_valid = 1'b0;
    logic               op_ready;
    logic               pe_in_valid;
    logic               pe_in_propagate;
    logic [SHIFT_W-1:0] pe_in_shift;
    logic               pe_out_valid;
    logic               busy;
    logic               done;
    logic               err_illegal;
    logic               err_timeout;
    logic [31:0]        perf_stall_cnt;
    logic [1:0]         dbg_state;

    int n_asserts = 0;
    int n_fail    = 0;

    // clock/reset block
    always #5 clk = ~clk;

    pe_stream_sequencer #(
        .CNT_W     (CNT_W),
        .SHIFT_W   (SHIFT_W),
        .DRAIN_MAX (DRAIN_MAX)
    ) dut (
        .CLK             (clk),
        .RST             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_rows        (cmd_rows),
        .cmd_shift       (cmd_shift),
        .op_valid        (op_valid),
        .op_ready        (op_ready),
        .pe_in_valid     (pe_in_valid),
        .pe_in_propagate (pe_in_propagate),
        .pe_in_shift     (pe_in_shift),
        .pe_out_valid    (pe_out_valid),
        .busy            (busy),
        .done            (done),
        .err_illegal     (err_illegal),
        .err_timeout     (err_timeout),
        .perf_stall_cnt  (perf_stall_cnt),
        .dbg_state       (dbg_state)
    );

    // PE model: echoes pe_in_valid three cycles later, up to echo_limit beats
    logic [2:0] pe_pipe = '0;
    int echo_seen  = 0;
    int echo_base  = 0;
    int echo_limit = 1000;

    always @(posedge clk) begin
        if (rst) pe_pipe <= '0;
        else     pe_pipe <= {pe_pipe[1:0], pe_in_valid};
        if (pe_out_valid) echo_seen <= echo_seen + 1;
    end

    assign pe_out_valid = pe_pipe[2] && ((echo_seen - echo_base) < echo_limit);

    // scoreboard
    logic [0:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // window monitor accumulators
    int   m_valid_cnt, m_rise, m_done_cnt, m_to_cnt, m_to_with_done, m_ill_cnt;
    int   m_done_idx, m_shift_bad;
    logic m_ready_at_done, m_prev;

    task automatic mon(input int n, input logic [SHIFT_W-1:0] exp_shift);
        m_valid_cnt = 0; m_rise = 0; m_done_cnt = 0; m_to_cnt = 0;
        m_to_with_done = 0; m_ill_cnt = 0; m_done_idx = -1; m_shift_bad = 0;
        m_ready_at_done = 1'b1;
        m_prev = pe_in_valid;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (pe_in_valid) m_valid_cnt++;
            if (pe_in_valid && !m_prev) m_rise++;
            m_prev = pe_in_valid;
            if (done) begin
                m_done_cnt++;
                if (m_done_idx < 0) begin
                    m_done_idx = i;
                    m_ready_at_done = cmd_ready;
                end
            end
            if (err_timeout) m_to_cnt++;
            if (err_timeout && done) m_to_with_done++;
            if (err_illegal) m_ill_cnt++;
            if (busy && (pe_in_shift !== exp_shift)) m_shift_bad++;
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [CNT_W-1:0] rows,
                            input logic [SHIFT_W-1:0] shift);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rows  = rows;
        cmd_shift = shift;
    endtask

    logic [0:0] pat [4];
    logic [0:0] exp_bit;

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_op_ready", op_ready, 0);
        chk("rst_in_valid", pe_in_valid, 0);
        chk("rst_prop", pe_in_propagate, 0);
        chk("rst_shift", pe_in_shift, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {done, err_illegal, err_timeout}, 0);
        chk("rst_perf", perf_stall_cnt, 0);
        chk("rst_state", dbg_state, IDLE);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", cmd_ready, 1);

        // PRELOAD rows=4, op_valid held
        send_cmd(2'b00, 8'd4, 6'd7);
        op_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("t1_busy", busy, 1);
        chk("t1_prop", pe_in_propagate, 1);
        chk("t1_shift", pe_in_shift, 0);
        chk("t1_state", dbg_state, STREAM);
        chk("t1_cmd_ready", cmd_ready, 0);
        mon(12, 6'd0);
        op_valid = 1'b0;
        chk("t1_valid_cnt", m_valid_cnt, 4);
        chk("t1_valid_rise", m_rise, 1);
        chk("t1_done_cnt", m_done_cnt, 1);
        chk("t1_done_idx", m_done_idx, 8);
        chk("t1_ready_at_done", m_ready_at_done, 0);
        chk("t1_errors", m_to_cnt + m_ill_cnt, 0);
        chk("t1_shift_hold", m_shift_bad, 0);
        chk("t1_ready_after", cmd_ready, 1);
        chk("t1_busy_after", busy, 0);

        // COMPUTE rows=3 shift=5, op_valid 1,0,1,1
        send_cmd(2'b01, 8'd3, 6'd5);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("t2_shift", pe_in_shift, 5);
        chk("t2_prop", pe_in_propagate, 1);
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back(pat[k]);
        op_valid = pat[0];
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_bit = exp_q.pop_front();
            chk($sformatf("t2_in_valid_%0d", k), pe_in_valid, exp_bit);
            chk($sformatf("t2_shift_%0d", k), pe_in_shift, 5);
            op_valid = (k < 3) ? pat[k+1] : 1'b0;
        end
        mon(8, 6'd5);
        chk("t2_done_cnt", m_done_cnt, 1);
        chk("t2_done_idx", m_done_idx, 4);
        chk("t2_shift_hold", m_shift_bad, 0);
        chk("t2_errors", m_to_cnt + m_ill_cnt, 0);
        chk("t2_stall", perf_stall_cnt, EXP_STALL);

        // COMPUTE rows=2, PE returns only one beat -> timeout
        echo_base  = echo_seen;
        echo_limit = 1;
        send_cmd(2'b01, 8'd2, 6'd3);
        op_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("t3_shift", pe_in_shift, 3);
        mon(22, 6'd3);
        op_valid = 1'b0;
        chk("t3_valid_cnt", m_valid_cnt, 2);
        chk("t3_done_cnt", m_done_cnt, 1);
        chk("t3_timeout_with_done", m_to_with_done, 1);
        chk("t3_timeout_cnt", m_to_cnt, 1);
        chk("t3_done_idx", m_done_idx, 17);
        echo_base  = echo_seen;
        echo_limit = 1000;

        // illegal op, then a PRELOAD still works
        send_cmd(2'b11, 8'd5, 6'd2);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("t4_err_illegal", err_illegal, 1);
        chk("t4_busy", busy, 0);
        chk("t4_prop", pe_in_propagate, 1);
        chk("t4_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        chk("t4_err_pulse", err_illegal, 0);
        chk("t4_busy2", busy, 0);
        send_cmd(2'b00, 8'd2, 6'd9);
        op_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("t4_pre_prop", pe_in_propagate, 0);
        chk("t4_pre_shift", pe_in_shift, 0);
        mon(9, 6'd0);
        op_valid = 1'b0;
        chk("t4_valid_cnt", m_valid_cnt, 2);
        chk("t4_done_idx", m_done_idx, 6);
        chk("t4_errors", m_to_cnt + m_ill_cnt, 0);

        // PRELOAD rows=0
        send_cmd(2'b00, 8'd0, 6'd0);
        op_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("t5_prop", pe_in_propagate, 1);
        chk("t5_state", dbg_state, DRAIN);
        chk("t5_op_ready", op_ready, 0);
        mon(4, 6'd0);
        op_valid = 1'b0;
        chk("t5_valid_cnt", m_valid_cnt, 0);
        chk("t5_done_idx", m_done_idx, 0);
        chk("t5_done_cnt", m_done_cnt, 1);

        // reset mid-STREAM at beat 2 of 8
        send_cmd(2'b01, 8'd8, 6'd4);
        op_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_streaming", pe_in_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        op_valid = 1'b0;
        chk("t6_outputs", {cmd_ready, op_ready, pe_in_valid, pe_in_propagate, busy,
                           done, err_illegal, err_timeout}, 0);
        chk("t6_shift", pe_in_shift, 0);
        chk("t6_perf", perf_stall_cnt, 0);
        mon(6, 6'd0);
        chk("t6_no_done", m_done_cnt + m_to_cnt, 0);
        chk("t6_ready", cmd_ready, 1);
        send_cmd(2'b00, 8'd1, 6'd0);
        op_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("t6_prop", pe_in_propagate, 1);
        mon(8, 6'd0);
        op_valid = 1'b0;
        chk("t6_valid_cnt", m_valid_cnt, 1);
        chk("t6_done_idx", m_done_idx, 5);
        chk("t6_errors", m_to_cnt + m_ill_cnt, 0);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
